// File: rtl/issue_pkg.sv
// Shared constants, FSM state type and the RV32I OP/OP-IMM decoder used by alu_issue.
package issue_pkg;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [5:0] ALU_ADDI  = 6'd18;
  localparam logic [5:0] ALU_SLTI  = 6'd19;
  localparam logic [5:0] ALU_SLTIU = 6'd20;
  localparam logic [5:0] ALU_XORI  = 6'd21;
  localparam logic [5:0] ALU_ORI   = 6'd22;
  localparam logic [5:0] ALU_ANDI  = 6'd23;
  localparam logic [5:0] ALU_SLLI  = 6'd24;
  localparam logic [5:0] ALU_SRLI  = 6'd25;
  localparam logic [5:0] ALU_SRAI  = 6'd26;
  localparam logic [5:0] ALU_ADD   = 6'd27;
  localparam logic [5:0] ALU_SUB   = 6'd28;
  localparam logic [5:0] ALU_SLL   = 6'd29;
  localparam logic [5:0] ALU_SLT   = 6'd30;
  localparam logic [5:0] ALU_SLTU  = 6'd31;
  localparam logic [5:0] ALU_XOR   = 6'd32;
  localparam logic [5:0] ALU_SRL   = 6'd33;
  localparam logic [5:0] ALU_SRA   = 6'd34;
  localparam logic [5:0] ALU_OR    = 6'd35;
  localparam logic [5:0] ALU_AND   = 6'd36;

  typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_EXEC, ST_WB} state_e;

  typedef struct packed {
    logic       legal;
    logic [5:0] op;
    logic       use_imm;
    logic       use_shamt;
  } dec_t;

  function automatic dec_t decode_instr(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [6:0] f7);
    dec_t d;
    d = '{legal: 1'b0, op: 6'd0, use_imm: 1'b0, use_shamt: 1'b0};
    if (opc == OPC_OP_IMM) begin
      d.use_imm = 1'b1;
      d.legal   = 1'b1;
      case (f3)
        3'b000: d.op = ALU_ADDI;
        3'b010: d.op = ALU_SLTI;
        3'b011: d.op = ALU_SLTIU;
        3'b100: d.op = ALU_XORI;
        3'b110: d.op = ALU_ORI;
        3'b111: d.op = ALU_ANDI;
        3'b001: begin
          d.op = ALU_SLLI;
          d.use_shamt = 1'b1;
          d.legal = (f7 == F7_BASE);
        end
        default: begin
          d.use_shamt = 1'b1;
          d.op = (f7 == F7_ALT) ? ALU_SRAI : ALU_SRLI;
          d.legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        end
      endcase
    end else if (opc == OPC_OP) begin
      // Only ADD/SUB and SRL/SRA accept the alternate funct7.
      d.legal = (f7 == F7_BASE);
      case (f3)
        3'b000: begin
          d.op = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          d.legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        end
        3'b001: d.op = ALU_SLL;
        3'b010: d.op = ALU_SLT;
        3'b011: d.op = ALU_SLTU;
        3'b100: d.op = ALU_XOR;
        3'b101: begin
          d.op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          d.legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        end
        3'b110: d.op = ALU_OR;
        default: d.op = ALU_AND;
      endcase
    end
    return d;
  endfunction
endpackage

// File: rtl/issue_regfile.sv
// 32-entry register file: two operand read ports, a debug read port, one write port; x0 reads 0.
module issue_regfile
  import issue_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [4:0]       waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [4:0]       raddr1_i,
  input  logic [4:0]       raddr2_i,
  input  logic [4:0]       dbg_addr_i,
  output logic [WIDTH-1:0] rdata1_o,
  output logic [WIDTH-1:0] rdata2_o,
  output logic [WIDTH-1:0] dbg_data_o
);
  logic [WIDTH-1:0] mem_q [32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o   = (raddr1_i   == 5'd0) ? '0 : mem_q[raddr1_i];
  assign rdata2_o   = (raddr2_i   == 5'd0) ? '0 : mem_q[raddr2_i];
  assign dbg_data_o = (dbg_addr_i == 5'd0) ? '0 : mem_q[dbg_addr_i];
endmodule

// File: rtl/alu_issue.sv
// Serial decode/issue unit for a combinational ALU: IDLE -> DECODE -> EXEC -> WB.
// Optional ALU_ISSUE_TRAP_EN: an illegal instruction halts issue until reset.
module alu_issue
  import issue_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int OPWIDTH = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [31:0]        instr,
  output logic               instr_ready,
  output logic [OPWIDTH-1:0] alu_op,
  output logic [WIDTH-1:0]   alu_in1,
  output logic [WIDTH-1:0]   alu_in2,
  input  logic [WIDTH-1:0]   alu_out,
  output logic               wb_valid,
  output logic [4:0]         wb_rd,
  output logic [WIDTH-1:0]   wb_data,
  output logic               illegal,
  output logic               halted,
  input  logic [4:0]         dbg_addr,
  output logic [WIDTH-1:0]   dbg_data
);
  state_e             state_q;
  dec_t               dec_q;
  logic [11:0]        imm_q;
  logic [4:0]         rs1_q;
  logic [4:0]         rd_q;
  logic [OPWIDTH-1:0] alu_op_q;
  logic [WIDTH-1:0]   alu_in1_q;
  logic [WIDTH-1:0]   alu_in2_q;
  logic [WIDTH-1:0]   result_q;
  logic               wb_valid_q;
  logic [4:0]         wb_rd_q;
  logic               illegal_q;
  logic               halted_q;
  logic [WIDTH-1:0]   rs1_data;
  logic [WIDTH-1:0]   rs2_data;
  logic [WIDTH-1:0]   imm_ext;
  dec_t               dec_in;

  // Decoding at accept lets the illegal pulse be a register that lands in DECODE.
  assign dec_in  = decode_instr(instr[6:0], instr[14:12], instr[31:25]);
  assign imm_ext = dec_q.use_shamt ? {{(WIDTH-5){1'b0}}, imm_q[4:0]}
                                   : {{(WIDTH-12){imm_q[11]}}, imm_q};

  issue_regfile #(.WIDTH(WIDTH)) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .we_i       (state_q == ST_WB),
    .waddr_i    (wb_rd_q),
    .wdata_i    (result_q),
    .raddr1_i   (rs1_q),
    .raddr2_i   (imm_q[4:0]),
    .dbg_addr_i (dbg_addr),
    .rdata1_o   (rs1_data),
    .rdata2_o   (rs2_data),
    .dbg_data_o (dbg_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dec_q      <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rd_q       <= '0;
      alu_op_q   <= '0;
      alu_in1_q  <= '0;
      alu_in2_q  <= '0;
      result_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      illegal_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (instr_valid && instr_ready) begin
            dec_q     <= dec_in;
            imm_q     <= instr[31:20];
            rs1_q     <= instr[19:15];
            rd_q      <= instr[11:7];
            illegal_q <= !dec_in.legal;
            state_q   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec_q.legal) begin
            alu_op_q  <= OPWIDTH'(dec_q.op);
            alu_in1_q <= rs1_data;
            alu_in2_q <= dec_q.use_imm ? imm_ext : rs2_data;
            state_q   <= ST_EXEC;
          end else begin
`ifdef ALU_ISSUE_TRAP_EN
            halted_q <= 1'b1;
`endif
            state_q <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          result_q   <= alu_out;
          wb_valid_q <= 1'b1;
          wb_rd_q    <= rd_q;
          state_q    <= ST_WB;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == ST_IDLE) && !halted_q;
  assign alu_op      = alu_op_q;
  assign alu_in1     = alu_in1_q;
  assign alu_in2     = alu_in2_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = result_q;
  assign illegal     = illegal_q;
  assign halted      = halted_q;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: an attached ALU plus an instruction-level model of the register file.
module tb_alu_issue;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic [5:0]  alu_op;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal, halted;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [32];
  logic [5:0]  prev_op;
  logic [31:0] prev_a, prev_b;

  typedef struct packed {
    logic        legal;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } exp_t;

  alu_issue #(.WIDTH(32), .OPWIDTH(6)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal), .halted(halted), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // The combinational ALU this unit drives.
  function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      6'd18, 6'd27: return a + b;
      6'd28:        return a - b;
      6'd19, 6'd30: return {31'b0, $signed(a) < $signed(b)};
      6'd20, 6'd31: return {31'b0, a < b};
      6'd21, 6'd32: return a ^ b;
      6'd22, 6'd35: return a | b;
      6'd23, 6'd36: return a & b;
      6'd24, 6'd29: return a << b[4:0];
      6'd25, 6'd33: return a >> b[4:0];
      6'd26, 6'd34: return $signed(a) >>> b[4:0];
      default:      return 32'h0;
    endcase
  endfunction

  always_comb alu_out = alu_fn(alu_op, alu_in1, alu_in2);

  // Instruction-level reference: what each RV32I word must do to the architectural state.
  function automatic exp_t ref_exec(input logic [31:0] w);
    exp_t e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [31:0] a, imm, rb;
    logic [4:0] sh;
    opc = w[6:0]; f7 = w[31:25]; f3 = w[14:12];
    a = mregs[w[19:15]]; rb = mregs[w[24:20]];
    imm = {{20{w[31]}}, w[31:20]}; sh = w[24:20];
    e = '0;
    if (opc == 7'h13) begin
      e.legal = 1'b1; e.b = imm;
      case (f3)
        3'd0: begin e.op = 18; e.r = a + imm; end
        3'd2: begin e.op = 19; e.r = ($signed(a) < $signed(imm)) ? 1 : 0; end
        3'd3: begin e.op = 20; e.r = (a < imm) ? 1 : 0; end
        3'd4: begin e.op = 21; e.r = a ^ imm; end
        3'd6: begin e.op = 22; e.r = a | imm; end
        3'd7: begin e.op = 23; e.r = a & imm; end
        3'd1: begin e.op = 24; e.b = {27'b0, sh}; e.r = a << sh; e.legal = (f7 == 0); end
        default: begin
          e.b = {27'b0, sh};
          if (f7 == 0) begin e.op = 25; e.r = a >> sh; end
          else if (f7 == 7'h20) begin e.op = 26; e.r = $signed(a) >>> sh; end
          else e.legal = 1'b0;
        end
      endcase
    end else if (opc == 7'h33) begin
      e.b = rb;
      e.legal = (f7 == 0);
      case (f3)
        3'd0: begin
          e.legal = (f7 == 0) || (f7 == 7'h20);
          e.op = (f7 == 7'h20) ? 6'd28 : 6'd27;
          e.r = (f7 == 7'h20) ? a - rb : a + rb;
        end
        3'd1: begin e.op = 29; e.r = a << rb[4:0]; end
        3'd2: begin e.op = 30; e.r = ($signed(a) < $signed(rb)) ? 1 : 0; end
        3'd3: begin e.op = 31; e.r = (a < rb) ? 1 : 0; end
        3'd4: begin e.op = 32; e.r = a ^ rb; end
        3'd5: begin
          e.legal = (f7 == 0) || (f7 == 7'h20);
          e.op = (f7 == 7'h20) ? 6'd34 : 6'd33;
          e.r = (f7 == 7'h20) ? $signed(a) >>> rb[4:0] : a >> rb[4:0];
        end
        3'd6: begin e.op = 35; e.r = a | rb; end
        default: begin e.op = 36; e.r = a & rb; end
      endcase
    end
    e.a = a;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek_reg(input string name, input logic [4:0] r, input logic [31:0] exp);
    dbg_addr = r;
    #1;
    check(name, dbg_data, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    prev_op = '0; prev_a = '0; prev_b = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, instr_ready, 1);
    check({tag, "_alu_op"}, alu_op, 0);
    check({tag, "_in1"}, alu_in1, 0);
    check({tag, "_in2"}, alu_in2, 0);
    check({tag, "_wb_valid"}, wb_valid, 0);
    check({tag, "_wb_rd"}, wb_rd, 0);
    check({tag, "_wb_data"}, wb_data, 0);
    check({tag, "_illegal"}, illegal, 0);
    check({tag, "_halted"}, halted, 0);
  endtask

  task automatic do_reset();
    instr_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    #2;
    reset = 1'b0;
    clear_model();
    tick();
  endtask

  task automatic wait_ready(output bit ok);
    for (int i = 0; i < 20 && !instr_ready; i++) tick();
    ok = instr_ready;
    if (!ok) check("ready_timeout", instr_ready, 1);
  endtask

  // Offer one word and follow it cycle by cycle against the model.
  task automatic issue(input logic [31:0] w);
    exp_t e;
    bit ok;
    e = ref_exec(w);
    instr = w;
    instr_valid = 1'b1;
    wait_ready(ok);
    if (!ok) begin instr_valid = 1'b0; return; end
    tick();
    instr_valid = 1'b0;
    check("decode_illegal", illegal, !e.legal);
    check("decode_wb_valid", wb_valid, 0);
    check("decode_ready", instr_ready, 0);
    if (!e.legal) begin
      tick();
      check("ill_wb_valid", wb_valid, 0);
      check("ill_illegal_cleared", illegal, 0);
      check("ill_op_kept", alu_op, prev_op);
      check("ill_in1_kept", alu_in1, prev_a);
      check("ill_in2_kept", alu_in2, prev_b);
`ifdef ALU_ISSUE_TRAP_EN
      check("trap_halted", halted, 1);
      check("trap_ready", instr_ready, 0);
      instr = 32'h00100093;
      instr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        check("trap_ready_held", instr_ready, 0);
        check("trap_no_wb", wb_valid, 0);
        check("trap_no_illegal", illegal, 0);
      end
      do_reset();
`else
      check("ill_halted", halted, 0);
      check("ill_ready", instr_ready, 1);
`endif
      $display("issue %h: illegal", w);
      return;
    end
    tick();
    check("exec_op", alu_op, e.op);
    check("exec_in1", alu_in1, e.a);
    check("exec_in2", alu_in2, e.b);
    check("exec_wb_valid", wb_valid, 0);
    prev_op = e.op; prev_a = e.a; prev_b = e.b;
    tick();
    check("wb_valid", wb_valid, 1);
    check("wb_rd", wb_rd, w[11:7]);
    check("wb_data", wb_data, e.r);
    check("wb_ready", instr_ready, 0);
    if (w[11:7] != 5'd0) mregs[w[11:7]] = e.r;
    tick();
    check("post_ready", instr_ready, 1);
    check("post_wb_valid", wb_valid, 0);
    peek_reg("post_rd_value", w[11:7], mregs[w[11:7]]);
    $display("issue %h: op=%0d in1=%h in2=%h rd=x%0d data=%h", w, e.op, e.a, e.b, w[11:7], e.r);
  endtask

  initial begin
    exp_t p;
    bit ok;
    clear_model();
    #1;
    check_reset_outputs("por");
    @(posedge clk);
    #2;
    reset = 1'b0;
    tick();
    check_reset_outputs("idle");
    peek_reg("por_x1", 5'd1, 0);

    // Pin the model on a few hand-decoded words.
    p = ref_exec(32'h00500093);
    check("pin_addi_op", p.op, 18);
    check("pin_addi_in2", p.b, 5);
    check("pin_addi_res", p.r, 5);

    issue(32'h00500093);            // ADDI x1,x0,5
    peek_reg("lit_x1", 5'd1, 32'd5);
    issue(32'hFFF00113);            // ADDI x2,x0,-1
    peek_reg("lit_x2", 5'd2, 32'hFFFFFFFF);
    issue(32'h402081B3);            // SUB x3,x1,x2
    peek_reg("lit_x3", 5'd3, 32'd6);
    p = ref_exec(32'h40315213);
    check("pin_srai_op", p.op, 26);
    check("pin_srai_in2", p.b, 3);
    issue(32'h40315213);            // SRAI x4,x2,3
    peek_reg("lit_x4", 5'd4, 32'hFFFFFFFF);
    issue(32'h00112333);            // SLT x6,x2,x1
    peek_reg("lit_x6", 5'd6, 32'd1);
    issue(32'h001133B3);            // SLTU x7,x2,x1
    issue(32'hFFF0C413);            // XORI x8,x1,-1
    peek_reg("lit_x8", 5'd8, 32'hFFFFFFFA);
    issue(32'h00409493);            // SLLI x9,x1,4
    peek_reg("lit_x9", 5'd9, 32'h50);
    issue(32'h00115533);            // SRL x10,x2,x1
    peek_reg("lit_x10", 5'd10, 32'h07FFFFFF);
    issue(32'h00700013);            // ADDI x0,x0,7
    peek_reg("lit_x0", 5'd0, 32'd0);

    issue(32'h00000003);            // LOAD: illegal opcode
    issue(32'h00500093);
    issue(32'h40409493);            // SLLI with funct7=0100000
    issue(32'h021081B3);            // MUL-encoded OP
    issue(32'h00500093);
    peek_reg("lit_x1_again", 5'd1, 32'd5);

    // Reset in the middle of EXEC abandons the instruction.
    instr = 32'h00900293;           // ADDI x5,x0,9
    instr_valid = 1'b1;
    wait_ready(ok);
    if (ok) begin
      tick();
      instr_valid = 1'b0;
      tick();
      check("mid_exec_op", alu_op, 18);
      check("mid_exec_in2", alu_in2, 9);
      reset = 1'b1;
      #1;
      check_reset_outputs("mid");
      @(posedge clk);
      #2;
      reset = 1'b0;
      clear_model();
      for (int i = 0; i < 4; i++) begin
        tick();
        check("mid_no_wb", wb_valid, 0);
      end
      check("mid_ready", instr_ready, 1);
      peek_reg("mid_x5", 5'd5, 0);
      peek_reg("mid_x1", 5'd1, 0);
      $display("reset during EXEC: instruction abandoned");
    end
    instr_valid = 1'b0;

    issue(32'h00900293);
    peek_reg("lit_x5", 5'd5, 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
